// File: rtl/dft64_sample_packer_if.sv
// dft64_sample_packer_if
// Purpose: bundles the sample-input handshake, the packed-beat bus toward
// dft64 and the done/status lines of dft64_sample_packer.
// Signals:
//   s_sample  signed Q8.8 input sample
//   s_valid   s_sample valid
//   s_ready   packer accepts a sample this cycle
//   samples   packed 128-bit beat (first sample of the beat in [127:112])
//   rel       samples valid for dft64, one cycle per beat
//   calculate frame in progress, enables dft64
//   done      dft64 result ready
//   frame_ok  one-cycle pulse when done ends a frame
//   err       one-cycle pulse on timeout
// Modports:
//   master  the packer side, which produces beats for dft64
//   slave   the environment side, which supplies samples and done
interface dft64_sample_packer_if;
  logic signed [15:0] s_sample;
  logic               s_valid;
  logic               s_ready;
  logic [127:0]       samples;
  logic               rel;
  logic               calculate;
  logic               done;
  logic               frame_ok;
  logic               err;

  modport master (
    input  s_sample, s_valid, done,
    output s_ready, samples, rel, calculate, frame_ok, err
  );

  modport slave (
    output s_sample, s_valid, done,
    input  s_ready, samples, rel, calculate, frame_ok, err
  );
endinterface

// File: rtl/dft64_sample_packer.sv
// dft64_sample_packer
// Purpose: front-end feeder for dft64. Accepts a serial stream of signed
// 16-bit samples, packs eight consecutive samples into one 128-bit beat,
// issues BEATS beats per 64-point frame, then holds off new input until
// dft64 raises done or TIMEOUT cycles expire.
// Parameters:
//   TIMEOUT  max cycles to wait for done after the last beat of a frame
//   BEATS    beats per frame (8 for dft64)
// Ports:
//   clk      sole clock, rising edge
//   sreset   synchronous active-high reset
//   bus      dft64_sample_packer_if.master (handshake, beat bus, status)
module dft64_sample_packer #(
  parameter int TIMEOUT = 6,
  parameter int BEATS   = 8
) (
  input logic                   clk,
  input logic                   sreset,
  dft64_sample_packer_if.master bus
);

  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic {
    FILL,
    WAIT_DONE
  } state_t;

  state_t         state;
  // Only the seven most recent samples need to be kept: the eighth arrives
  // on the accepting cycle and is concatenated directly into the beat.
  logic [111:0]   sh;
  logic [2:0]     scnt;
  logic [2:0]     bcnt;
  logic [WW-1:0]  wcnt;
  logic [127:0]   samples_r;
  logic           rel_r;
  logic           calculate_r;
  logic           frame_ok_r;
  logic           err_r;
  logic           accept;

  // Input is accepted whenever the packer is filling; ready depends only on
  // the state so it never combinationally follows s_valid.
  assign bus.s_ready = (state == FILL);
  assign accept      = bus.s_valid && (state == FILL);

  assign bus.samples   = samples_r;
  assign bus.rel       = rel_r;
  assign bus.calculate = calculate_r;
  assign bus.frame_ok  = frame_ok_r;
  assign bus.err       = err_r;

  // Main controller. In FILL each accepted sample shifts into the history
  // register; every eighth one completes a beat that is registered onto
  // samples with a one-cycle rel. The last beat of a frame moves to
  // WAIT_DONE, where done ends the frame, or the wait counter expires and
  // flags err. done is checked before the timeout so it wins a tie.
  // rel, frame_ok and err default low each cycle so they are single pulses.
  always_ff @(posedge clk) begin
    if (sreset) begin
      state       <= FILL;
      sh          <= '0;
      scnt        <= '0;
      bcnt        <= '0;
      wcnt        <= '0;
      samples_r   <= '0;
      rel_r       <= 1'b0;
      calculate_r <= 1'b0;
      frame_ok_r  <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      rel_r      <= 1'b0;
      frame_ok_r <= 1'b0;
      err_r      <= 1'b0;
      case (state)
        FILL: begin
          if (accept) begin
            sh <= {sh[95:0], bus.s_sample};
            if (scnt == 3'd0 && bcnt == 3'd0) begin
              calculate_r <= 1'b1;
            end
            if (scnt == 3'd7) begin
              samples_r <= {sh, bus.s_sample};
              rel_r     <= 1'b1;
              scnt      <= 3'd0;
              if (bcnt == 3'(BEATS - 1)) begin
                bcnt  <= 3'd0;
                wcnt  <= '0;
                state <= WAIT_DONE;
              end else begin
                bcnt <= bcnt + 3'd1;
              end
            end else begin
              scnt <= scnt + 3'd1;
            end
          end
        end
        WAIT_DONE: begin
          if (bus.done) begin
            frame_ok_r  <= 1'b1;
            calculate_r <= 1'b0;
            state       <= FILL;
          end else if (wcnt == WW'(TIMEOUT - 1)) begin
            err_r       <= 1'b1;
            calculate_r <= 1'b0;
            state       <= FILL;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
